parking_controller_multi: RTL and testbench

Multi-slot parking gate controller. It tracks lot occupancy up to a parametrised capacity and checks a parametrised two-field password with an entry timeout. Wrong attempts are limited; exceeding the limit triggers a timed lockout with an alarm. It drives the gate and the status LEDs at the lot entrance, and counts departures from a separate exit-lane strobe.

---
 rtl/parking_controller_multi.sv | 172 +++++++++++++++++
 tb/tb_parking_controller_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_controller_multi.sv
// rtl/parking_controller_multi.sv - multi-slot parking gate controller
// Occupancy tracking, two-field password check with timeout, lockout and blinking LEDs.
module parking_controller_multi #(
  parameter int                  CAPACITY       = 8,
  parameter int                  PW_WIDTH       = 4,
  parameter logic [PW_WIDTH-1:0] PASS_1         = PW_WIDTH'(1),
  parameter logic [PW_WIDTH-1:0] PASS_2         = PW_WIDTH'(2),
  parameter int                  TIMEOUT_CYCLES = 32,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  LOCK_CYCLES    = 64,
  parameter int                  BLINK_DIV      = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sensor_entrance,
  input  logic                             sensor_exit,
  input  logic                             car_depart,
  input  logic [PW_WIDTH-1:0]              password_1,
  input  logic [PW_WIDTH-1:0]              password_2,
  input  logic                             pass_valid,
  output logic                             gate_open,
  output logic                             GREEN_LED,
  output logic                             RED_LED,
  output logic                             alarm,
  output logic                             full,
  output logic [$clog2(CAPACITY+1)-1:0]    occupancy
);

  localparam int OW   = $clog2(CAPACITY + 1);
  localparam int TMAX = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_TRIES + 1);
  localparam int DW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [OW-1:0] CAP = OW'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_WRONG  = 3'd2,
    S_RIGHT  = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] tries_q, tries_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;
  logic          full_q, full_d;
  logic          gate_q, gate_d;
  logic          alarm_q, alarm_d;
  logic          green_q, green_d;
  logic          red_q, red_d;
  logic          match, inc, dec;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tries_d = tries_q;
    match   = pass_valid && (password_1 == PASS_1) && (password_2 == PASS_2);

    // Saturating occupancy; an entry and a departure in one cycle cancel out.
    inc   = (state_q == S_RIGHT) && sensor_exit;
    dec   = car_depart && (occ_q != '0);
    occ_d = occ_q;
    if (inc && !dec && occ_q != CAP) occ_d = occ_q + OW'(1);
    else if (dec && !inc)            occ_d = occ_q - OW'(1);
    full_d = (occ_d == CAP);

    case (state_q)
      S_IDLE: begin
        if (sensor_entrance && !full_q) begin
          state_d = S_WAIT;
          timer_d = '0;
          tries_d = '0;
        end
      end
      S_WAIT, S_WRONG: begin
        timer_d = timer_q + TW'(1);
        if (match) begin
          state_d = S_RIGHT;
        end else if (pass_valid) begin
          tries_d = tries_q + RW'(1);
          timer_d = '0;
          state_d = (tries_d == RW'(MAX_TRIES)) ? S_LOCKED : S_WRONG;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_RIGHT: begin
        if (sensor_exit) begin
          if (sensor_entrance && occ_d != CAP) begin
            state_d = S_WAIT;
            timer_d = '0;
            tries_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOCKED: begin
        if (timer_q == TW'(LOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
          tries_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Blink divider restarts on every state change so blinking begins dark.
    div_d   = div_q + DW'(1);
    phase_d = phase_q;
    if (state_d != state_q) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (div_q == DW'(BLINK_DIV - 1)) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end

    gate_d  = (state_d == S_RIGHT);
    alarm_d = (state_d == S_LOCKED);
    green_d = (state_d == S_RIGHT) && phase_d;
    case (state_d)
      S_IDLE:   red_d = full_d;
      S_WAIT:   red_d = 1'b1;
      S_WRONG:  red_d = phase_d;
      S_LOCKED: red_d = phase_d;
      default:  red_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      tries_q <= '0;
      occ_q   <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      full_q  <= 1'b0;
      gate_q  <= 1'b0;
      alarm_q <= 1'b0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
      occ_q   <= occ_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      full_q  <= full_d;
      gate_q  <= gate_d;
      alarm_q <= alarm_d;
      green_q <= green_d;
      red_q   <= red_d;
    end
  end

  assign gate_open = gate_q;
  assign alarm     = alarm_q;
  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign full      = full_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_parking_controller_multi.sv
// tb/tb_parking_controller_multi.sv - directed bench for parking_controller_multi
module tb_parking_controller_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_entrance = 1'b0;
  logic       sensor_exit = 1'b0;
  logic       car_depart = 1'b0;
  logic [3:0] password_1 = 4'h0;
  logic [3:0] password_2 = 4'h0;
  logic       pass_valid = 1'b0;
  logic       gate_open, GREEN_LED, RED_LED, alarm, full;
  logic [3:0] occupancy;

  int n_vec = 0;
  int n_bad = 0;

  parking_controller_multi dut (
    .clk             (clk),
    .reset           (reset),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .car_depart      (car_depart),
    .password_1      (password_1),
    .password_2      (password_2),
    .pass_valid      (pass_valid),
    .gate_open       (gate_open),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .alarm           (alarm),
    .full            (full),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_pw(input logic [3:0] p1, input logic [3:0] p2);
    password_1 = p1;
    password_2 = p2;
    pass_valid = 1'b1;
    tick();
    pass_valid = 1'b0;
  endtask

  task automatic enter_car();
    sensor_entrance = 1'b1;
    tick();
    sensor_entrance = 1'b0;
    strobe_pw(4'h1, 4'h2);
    sensor_exit = 1'b1;
    tick();
    sensor_exit = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    expect_eq("rst_gate", gate_open, 0);
    expect_eq("rst_leds", {GREEN_LED, RED_LED}, 0);
    expect_eq("rst_alarm", alarm, 0);
    expect_eq("rst_occ", occupancy, 0);
    expect_eq("rst_full", full, 0);
    reset = 1'b0;

    // correct entry
    sensor_entrance = 1'b1;
    tick();
    expect_eq("wait_red", RED_LED, 1);
    strobe_pw(4'h1, 4'h2);
    expect_eq("right_gate", gate_open, 1);
    expect_eq("right_green_off", GREEN_LED, 0);
    expect_eq("right_red", RED_LED, 0);
    repeat (4) tick();
    expect_eq("right_green_on", GREEN_LED, 1);
    sensor_entrance = 1'b0;
    sensor_exit = 1'b1;
    tick();
    sensor_exit = 1'b0;
    expect_eq("entry_occ", occupancy, 1);
    expect_eq("entry_gate", gate_open, 0);
    expect_eq("entry_red", RED_LED, 0);

    // lockout
    sensor_entrance = 1'b1;
    tick();
    sensor_entrance = 1'b0;
    strobe_pw(4'h3, 4'h3);
    expect_eq("wrong1_red", RED_LED, 0);
    expect_eq("wrong1_alarm", alarm, 0);
    repeat (4) tick();
    expect_eq("wrong1_blink", RED_LED, 1);
    strobe_pw(4'h3, 4'h3);
    expect_eq("wrong2_red", RED_LED, 1);
    expect_eq("wrong2_alarm", alarm, 0);
    strobe_pw(4'h3, 4'h3);
    expect_eq("lock_alarm", alarm, 1);
    expect_eq("lock_red0", RED_LED, 0);
    for (int k = 1; k < 64; k++) begin
      password_1 = 4'h1;
      password_2 = 4'h2;
      pass_valid = (k >= 8 && k <= 12);
      tick();
      expect_eq($sformatf("lock_alarm_k%0d", k), alarm, 1);
      expect_eq($sformatf("lock_red_k%0d", k), RED_LED, (k / 4) % 2);
      expect_eq($sformatf("lock_gate_k%0d", k), gate_open, 0);
    end
    pass_valid = 1'b0;
    tick();
    expect_eq("unlock_alarm", alarm, 0);
    expect_eq("unlock_red", RED_LED, 0);
    expect_eq("unlock_occ", occupancy, 1);

    // timeout
    sensor_entrance = 1'b1;
    tick();
    sensor_entrance = 1'b0;
    repeat (31) tick();
    expect_eq("timeout_still_wait", RED_LED, 1);
    tick();
    expect_eq("timeout_idle_red", RED_LED, 0);
    expect_eq("timeout_occ", occupancy, 1);

    // full lot
    repeat (7) enter_car();
    expect_eq("full_occ", occupancy, 8);
    expect_eq("full_flag", full, 1);
    expect_eq("full_red", RED_LED, 1);
    sensor_entrance = 1'b1;
    repeat (2) tick();
    strobe_pw(4'h1, 4'h2);
    sensor_entrance = 1'b0;
    expect_eq("full_no_gate", gate_open, 0);
    expect_eq("full_red_solid", RED_LED, 1);
    car_depart = 1'b1;
    tick();
    car_depart = 1'b0;
    expect_eq("depart_occ", occupancy, 7);
    expect_eq("depart_full", full, 0);
    expect_eq("depart_red", RED_LED, 0);
    enter_car();
    expect_eq("refill_occ", occupancy, 8);
    expect_eq("refill_full", full, 1);
    car_depart = 1'b1;
    tick();
    car_depart = 1'b0;

    // tailgate with simultaneous departure
    sensor_entrance = 1'b1;
    tick();
    strobe_pw(4'h1, 4'h2);
    expect_eq("tg_gate", gate_open, 1);
    sensor_exit = 1'b1;
    car_depart = 1'b1;
    tick();
    sensor_exit = 1'b0;
    car_depart = 1'b0;
    sensor_entrance = 1'b0;
    expect_eq("tg_occ", occupancy, 7);
    expect_eq("tg_gate_closed", gate_open, 0);
    expect_eq("tg_wait_red", RED_LED, 1);
    car_depart = 1'b1;
    repeat (7) tick();
    expect_eq("drain_occ", occupancy, 0);
    tick();
    car_depart = 1'b0;
    expect_eq("drain_floor", occupancy, 0);

    // async reset mid-RIGHT_PASS
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) enter_car();
    expect_eq("pre_occ", occupancy, 5);
    sensor_entrance = 1'b1;
    tick();
    sensor_entrance = 1'b0;
    strobe_pw(4'h1, 4'h2);
    repeat (4) tick();
    expect_eq("pre_gate", gate_open, 1);
    expect_eq("pre_green", GREEN_LED, 1);
    #2;
    reset = 1'b1;
    #1;
    expect_eq("arst_gate", gate_open, 0);
    expect_eq("arst_leds", {GREEN_LED, RED_LED}, 0);
    expect_eq("arst_occ", occupancy, 0);
    tick();
    reset = 1'b0;
    tick();
    expect_eq("post_gate", gate_open, 0);
    expect_eq("post_red", RED_LED, 0);
    expect_eq("post_occ", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
